// File: rtl/dmem_port_arb.sv
// Single SRAM port arbiter between store-buffer retirements and loads.
// Loads complete in exactly one cycle, either forwarded or read from SRAM.
module dmem_port_arb #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TAG_W      = 6,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ld_req,
  output logic              o_ld_ready,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [TAG_W-1:0]  i_ld_tag,
  input  logic              i_stbuf_addr_hit,
  input  logic [DATA_W-1:0] i_stbuf_rd_data,
  input  logic              i_stbuf_ret_pend,
  output logic              o_dmem_occupy,
  input  logic              i_ret_stbuf,
  input  logic [ADDR_W-1:0] i_ret_stbuf_addr,
  input  logic [DATA_W-1:0] i_ret_stbuf_data,
  input  logic              i_flush,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_ld_fin,
  output logic [DATA_W-1:0] o_ld_data,
  output logic [TAG_W-1:0]  o_ld_tag,
  output logic              o_proto_err
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0]  starve_q, starve_d;
  logic              rsp_vld_q, rsp_vld_d;
  logic              rsp_src_q, rsp_src_d;   // 1: SRAM, 0: forwarded
  logic [DATA_W-1:0] fwd_data_q, fwd_data_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              proto_err_q, proto_err_d;

  logic yield_s;
  logic acc_s;
  logic occupy_s;

  assign yield_s       = (starve_q == CNT_MAX);
  assign o_ld_ready    = !yield_s && !i_flush;
  assign acc_s         = i_ld_req && o_ld_ready;
  assign occupy_s      = acc_s && !i_stbuf_addr_hit;
  assign o_dmem_occupy = occupy_s;

  // A late flush squashes the response; the SRAM read itself is harmless.
  assign o_ld_fin    = rsp_vld_q && !i_flush;
  assign o_ld_data   = rsp_src_q ? i_dmem_rdata : fwd_data_q;
  assign o_ld_tag    = tag_q;
  assign o_proto_err = proto_err_q;

  // SRAM port mux: a memory-path load always wins, otherwise a retirement.
  always_comb begin
    o_dmem_req   = 1'b0;
    o_dmem_we    = 1'b0;
    o_dmem_addr  = {ADDR_W{1'b0}};
    o_dmem_wdata = {DATA_W{1'b0}};
    if (occupy_s) begin
      o_dmem_req  = 1'b1;
      o_dmem_addr = i_ld_addr;
    end else if (i_ret_stbuf) begin
      o_dmem_req   = 1'b1;
      o_dmem_we    = 1'b1;
      o_dmem_addr  = i_ret_stbuf_addr;
      o_dmem_wdata = i_ret_stbuf_data;
    end else begin
      o_dmem_req = 1'b0;
    end
  end

  // Next-state for the starvation counter, response pipe and error flag.
  always_comb begin
    starve_d    = starve_q;
    rsp_vld_d   = acc_s;
    rsp_src_d   = rsp_src_q;
    fwd_data_d  = fwd_data_q;
    tag_d       = tag_q;
    proto_err_d = proto_err_q || (i_ret_stbuf && occupy_s);

    if (!i_stbuf_ret_pend || i_ret_stbuf) begin
      starve_d = {CNT_W{1'b0}};
    end else if (occupy_s && (starve_q != CNT_MAX)) begin
      starve_d = starve_q + CNT_ONE;
    end else begin
      starve_d = starve_q;
    end

    if (acc_s) begin
      rsp_src_d  = !i_stbuf_addr_hit;
      fwd_data_d = i_stbuf_rd_data;
      tag_d      = i_ld_tag;
    end else begin
      rsp_src_d = rsp_src_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q    <= {CNT_W{1'b0}};
      rsp_vld_q   <= 1'b0;
      rsp_src_q   <= 1'b0;
      fwd_data_q  <= {DATA_W{1'b0}};
      tag_q       <= {TAG_W{1'b0}};
      proto_err_q <= 1'b0;
    end else begin
      starve_q    <= starve_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_src_q   <= rsp_src_d;
      fwd_data_q  <= fwd_data_d;
      tag_q       <= tag_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule

// File: doc/dmem_port_arb.md
Name: dmem_port_arb

Overview:
- Single-port data-memory arbiter directly downstream of the store buffer.
- Merges committed-store retirements from the store buffer with load requests from the load unit onto one synchronous SRAM port (read latency 1).
- Generates the store buffer's dmem-occupy stall. Returns load results, either forwarded from the store buffer or read from SRAM.
- Includes a starvation guard so committed stores cannot be blocked indefinitely by back-to-back loads.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width (word access only).
- TAG_W, 6, load tag width (ROB/LSQ id).
- STARVE_MAX, 4, max consecutive cycles a pending retirement may be blocked by loads (must be ≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_ld_req  in  1  load request valid
- o_ld_ready  out  1  load request accepted when high with i_ld_req
- i_ld_addr  in  ADDR_W  load address; also drives store-buffer search address
- i_ld_tag  in  TAG_W  load tag
- i_stbuf_addr_hit  in  1  store buffer holds matching address (same-cycle, combinational on i_ld_addr)
- i_stbuf_rd_data  in  DATA_W  youngest matching store data
- i_stbuf_ret_pend  in  1  store buffer head is valid and committed
- o_dmem_occupy  out  1  port taken by a load this cycle; store buffer must not retire
- i_ret_stbuf  in  1  store retirement this cycle
- i_ret_stbuf_addr  in  ADDR_W  retiring store address
- i_ret_stbuf_data  in  DATA_W  retiring store data
- i_flush  in  1  pipeline flush (kills loads, never stores)
- o_dmem_req  out  1  SRAM access enable
- o_dmem_we  out  1  SRAM write enable
- o_dmem_addr  out  ADDR_W  SRAM address
- o_dmem_wdata  out  DATA_W  SRAM write data
- i_dmem_rdata  in  DATA_W  SRAM read data, valid the cycle after a read
- o_ld_fin  out  1  load result valid
- o_ld_data  out  DATA_W  load result
- o_ld_tag  out  TAG_W  tag of the finishing load
- o_proto_err  out  1  sticky: i_ret_stbuf seen while o_dmem_occupy=1

Behaviour:
- Reset: registered outputs o_ld_fin, o_ld_data, o_ld_tag, o_proto_err and the internal starve_cnt, rsp_src, rsp_vld all reset to 0.
- yield = (starve_cnt == STARVE_MAX). o_ld_ready = !yield && !i_flush (combinational).
- Load accept: acc = i_ld_req && o_ld_ready.
- Forward path: acc && i_stbuf_addr_hit at cycle N.
  - No SRAM access; o_dmem_occupy=0.
  - Cycle N+1: o_ld_fin=1, o_ld_data = i_stbuf_rd_data captured at N, o_ld_tag = tag captured at N.
- Memory path: acc && !i_stbuf_addr_hit at cycle N.
  - o_dmem_occupy=1, o_dmem_req=1, o_dmem_we=0, o_dmem_addr=i_ld_addr.
  - Cycle N+1: o_ld_fin=1, o_ld_data=i_dmem_rdata, o_ld_tag=captured tag.
  - rsp_src (fwd/mem) selects the data source at N+1.
- Store retirement: i_ret_stbuf && !o_dmem_occupy.
  - Same cycle: o_dmem_req=1, o_dmem_we=1, address and data passed through.
  - A forwarded load and a retirement may share a cycle.
- Protocol violation: i_ret_stbuf && o_dmem_occupy.
  - Load wins the port; the write is dropped.
  - o_proto_err sets and holds until reset.
- Idle: o_dmem_req=0; o_dmem_addr/o_dmem_wdata are don't-care but driven 0.
- Latency: exactly 1 cycle for every accepted load, on both paths. One load accepted per cycle, fully pipelined, no internal queue.
- Starvation counter, evaluated each cycle:
  - Cleared to 0 if !i_stbuf_ret_pend or i_ret_stbuf.
  - Else incremented when o_dmem_occupy=1, saturating at STARVE_MAX.
  - Else held.
  - While yield=1, loads are refused and occupy=0, so the head store retires and the counter clears the next cycle.
- Flush:
  - i_flush at N+1 suppresses o_ld_fin for the load accepted at N. The SRAM read still completes harmlessly.
  - i_flush at N blocks acceptance at N.
  - Stores and starve_cnt are unaffected.
- Reset mid-operation: an in-flight response is dropped (o_ld_fin=0 next cycle); o_proto_err clears.
- Same-address hazard: a load that hits a store retiring in the same cycle takes the forwarded data. A load read at N+1 after a write at N returns the written data (SRAM write-then-read ordering).

Test Plan:
- Load memory path: SRAM[0x100]=0xDEADBEEF; i_ld_req addr 0x100 tag 5, no hit -> occupy=1 and read at N; at N+1 o_ld_fin=1, data 0xDEADBEEF, tag 5.
- Forwarding: hit=1, rd_data 0x12345678, addr 0x200 tag 3 -> no o_dmem_req; N+1 data 0x12345678 tag 3; a simultaneous retire to 0x300 writes SRAM.
- Starvation with STARVE_MAX=4: ret_pend=1 and loads every cycle (no hit) -> occupy high cycles 0-3; cycle 4 o_ld_ready=0, occupy=0; retire 0x40/0xA5A5A5A5 writes; cycle 5 loads resume with counter at 0.
- Flush: load accepted at N, i_flush at N+1 -> o_ld_fin=0 at N+1. i_flush at N with i_ld_req -> o_ld_ready=0, no SRAM access.
- Protocol error: force i_ret_stbuf=1 during a memory-path load -> no write issued, o_proto_err=1 persisting until rst_n=0.
- Back-to-back mix: loads tags 1,2,3 with hit pattern 0,1,0 -> three consecutive o_ld_fin with correct sources and tags, in order.
